fifo_sync_fwft: RTL and testbench
=================================

Name: fifo_sync_fwft

Overview:
Parametrised single-clock FIFO, successor to the fixed 8x8 synchronous FIFO. Generalises data width and depth, and adds:
- selectable first-word-fall-through (FWFT) read mode
- occupancy count and programmable almost-full / almost-empty thresholds
- write-while-full when a read is accepted in the same cycle
- synchronous flush
- overflow/underflow error pulses

Used as the generic buffering stage between octree pipeline stages.

Parameters:
- DATA_WIDTH, 64, bits per entry (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
- FWFT, 1, 1 = head word visible on rdata without a read; 0 = registered read, one cycle latency

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear, highest priority
- wr_en  input  1  write request
- wdata  input  DATA_WIDTH  write data
- rd_en  input  1  read (pop) request
- rdata  output  DATA_WIDTH  read data
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_empty  output  1  count <= AEMPTY_TH
- almost_full  output  1  count >= AFULL_TH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: rejected write
- underflow  output  1  one-cycle pulse: rejected read

Behaviour:
- Reset (async, rst_n low) forces:
  - wr_ptr = 0, rd_ptr = 0, count = 0, rdata = 0, overflow = 0, underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the count register, not an extra pointer bit.
- rd_acc = rd_en & !empty & !flush.
- wr_acc = wr_en & !flush & (!full | rd_acc). Write into a full FIFO is legal when a read is accepted in the same cycle.
- Read and write accepted in the same cycle: count unchanged, both pointers advance. When empty, only the write is accepted and the read is rejected.
- count update: count + wr_acc - rd_acc each cycle. All status flags are combinational compares of the registered count, so they are valid the cycle after the causing edge.
- overflow <= wr_en & !wr_acc & !flush.
- underflow <= rd_en & !rd_acc & !flush.
- Both error pulses are registered, high for exactly one cycle per rejected request.
- FWFT=1:
  - rdata = mem[rd_ptr] combinationally; valid whenever !empty, don't-care when empty.
  - A word written into an empty FIFO appears on rdata, and empty deasserts, one cycle after the write edge.
  - rd_en pops the current head.
- FWFT=0:
  - On rd_acc, rdata <= mem[rd_ptr] at the clock edge, i.e. one cycle latency.
  - rdata holds its value otherwise, including on rejected reads.
- flush:
  - Pointers and count go to 0.
  - rdata is cleared to 0 in FWFT=0 mode.
  - wr_en and rd_en are ignored that cycle; no error pulses are generated.
  - Flags update the next cycle.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk; buffered contents are lost.
- Data ordering is strict FIFO across every wrap-around.

Decomposition:
- Shared package octree_fifo_pkg:
  - function for the count width, $clog2(DEPTH)+1
  - parameter-legality check constants (DEPTH power of two, threshold ranges), enforced by elaboration-time assertions in the module
- One natural sub-module: fifo_ram_1r1w.
  - DEPTH x DATA_WIDTH register array, synchronous write port, asynchronous read port.
  - FWFT=0 mode adds its output register in fifo_sync_fwft.

Test Plan:
- DEPTH=16, FWFT=1:
  - Reset, then write 0x00..0x0F on 16 consecutive cycles -> full=1, count=16, almost_full=1 from count=14.
  - Read 16 cycles -> rdata sequence 0x00..0x0F, empty=1 after the last pop.
- Full FIFO (count=16), wr_en=1, rd_en=1, wdata=0xAA -> count stays 16, overflow=0, head advances; 0xAA is read out 16 pops later.
- Empty FIFO, rd_en=1 for one cycle -> underflow pulses high for exactly one cycle, count=0, rdata unchanged (FWFT=0).
- Full FIFO, wr_en=1, rd_en=0 -> overflow=1 for one cycle, count=16.
- FWFT=0: write 0x11, 0x22, then rd_en one cycle -> rdata=0x11 on the cycle after rd_en; second read -> 0x22.
- Write 5 entries, assert flush with wr_en=1 -> next cycle count=0, empty=1, no overflow.
- Write 5 entries, assert rst_n low mid-burst -> all outputs at reset values immediately.
- Continuous random wr_en/rd_en for 1000 cycles with pointer wrap -> scoreboard order match, count always in 0..16.

Source files
------------

// File: rtl/octree_fifo_pkg.sv
// Shared helpers for the octree pipeline FIFOs: count sizing and parameter legality checks.
package octree_fifo_pkg;

  // Occupancy counter width; one extra bit so DEPTH itself is representable.
  function automatic int unsigned fifo_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointers wrap naturally only when DEPTH is a power of two.
  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit fifo_afull_th_ok(input int unsigned depth, input int unsigned th);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit fifo_aempty_th_ok(input int unsigned depth, input int unsigned th);
    return th <= (depth - 1);
  endfunction

  function automatic bit fifo_width_ok(input int unsigned width);
    return width >= 1;
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram_1r1w #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store wdata at waddr on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Parametrised single-clock FIFO with optional first-word-fall-through, occupancy count,
// almost-full/almost-empty thresholds, write-while-full on a same-cycle read, synchronous
// flush and registered overflow/underflow pulses.
module fifo_sync_fwft
  import octree_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2,
  parameter int unsigned FWFT       = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic [DATA_WIDTH-1:0]               wdata,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_empty,
  output logic                                almost_full,
  output logic [fifo_count_width(DEPTH)-1:0]  count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = fifo_count_width(DEPTH);

  localparam bit WidthLegal  = fifo_width_ok(DATA_WIDTH);
  localparam bit DepthLegal  = fifo_depth_ok(DEPTH);
  localparam bit AfullLegal  = fifo_afull_th_ok(DEPTH, AFULL_TH);
  localparam bit AemptyLegal = fifo_aempty_th_ok(DEPTH, AEMPTY_TH);

  if (!WidthLegal) begin : gen_width_chk
    $error("fifo_sync_fwft: DATA_WIDTH must be >= 1");
  end
  if (!DepthLegal) begin : gen_depth_chk
    $error("fifo_sync_fwft: DEPTH must be a power of two >= 2");
  end
  if (!AfullLegal) begin : gen_afull_chk
    $error("fifo_sync_fwft: AFULL_TH must lie in 1..DEPTH");
  end
  if (!AemptyLegal) begin : gen_aempty_chk
    $error("fifo_sync_fwft: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status flags decode the registered count only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
  assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO may still take a write when the head is popped in the same cycle.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & ~flush & (~full | rd_acc);

  // Next-state for pointers, occupancy and error pulses; flush overrides everything.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & ~wr_acc & ~flush;
    underflow_d = rd_en & ~rd_acc & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : gen_fwft
    // Head word falls through; forced to zero while empty so reset leaves rdata at 0.
    assign rdata = empty ? '0 : ram_rdata;
  end else begin : gen_reg_read
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (flush) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= ram_rdata;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft: one FWFT and one registered-read instance share stimulus.
module tb_fifo_sync_fwft;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;

  logic [DW-1:0] rdata_f, rdata_r;
  logic          empty_f, full_f, aempty_f, afull_f, ovf_f, unf_f;
  logic          empty_r, full_r, aempty_r, afull_r, ovf_r, unf_r;
  logic [4:0]    count_f, count_r;

  int unsigned n_checks;
  int unsigned n_fail;

  fifo_sync_fwft #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2),
    .FWFT       (1)
  ) u_dut_fwft (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata_f),
    .empty        (empty_f),
    .full         (full_f),
    .almost_empty (aempty_f),
    .almost_full  (afull_f),
    .count        (count_f),
    .overflow     (ovf_f),
    .underflow    (unf_f)
  );

  fifo_sync_fwft #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2),
    .FWFT       (0)
  ) u_dut_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata_r),
    .empty        (empty_r),
    .full         (full_r),
    .almost_empty (aempty_r),
    .almost_full  (afull_r),
    .count        (count_r),
    .overflow     (ovf_r),
    .underflow    (unf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, 64'(count_f), 64'd0);
    check({tag, " empty"}, 64'(empty_f), 64'd1);
    check({tag, " full"}, 64'(full_f), 64'd0);
    check({tag, " aempty"}, 64'(aempty_f), 64'd1);
    check({tag, " afull"}, 64'(afull_f), 64'd0);
    check({tag, " ovf"}, 64'(ovf_f), 64'd0);
    check({tag, " unf"}, 64'(unf_f), 64'd0);
    check({tag, " rdata_f"}, 64'(rdata_f), 64'd0);
    check({tag, " rdata_r"}, 64'(rdata_r), 64'd0);
    check({tag, " count_r"}, 64'(count_r), 64'd0);
  endtask

  logic [DW-1:0] sb [$];
  int            mcnt;
  logic [DW-1:0] exp_v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wdata    = '0;

    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x00..0x0F; almost_full from count 14.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = DW'(i);
      tick();
      check("fill count", 64'(count_f), 64'(i + 1));
      check("fill afull", 64'(afull_f), 64'((i + 1) >= 14));
      check("fill empty", 64'(empty_f), 64'd0);
    end
    check("full flag", 64'(full_f), 64'd1);
    check("fwft head", 64'(rdata_f), 64'h00);

    // Write into full without read is rejected.
    wdata = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("ovf pulse", 64'(ovf_f), 64'd1);
    check("ovf count", 64'(count_f), 64'd16);
    check("ovf head", 64'(rdata_f), 64'h00);
    tick();
    check("ovf clear", 64'(ovf_f), 64'd0);

    // Write while full with a simultaneous pop.
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'hAA;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wwf count", 64'(count_f), 64'd16);
    check("wwf ovf", 64'(ovf_f), 64'd0);
    check("wwf head", 64'(rdata_f), 64'h01);
    check("wwf rdata_r", 64'(rdata_r), 64'h00);

    // Drain: 0x01..0x0F then 0xAA.
    for (int i = 0; i < 16; i++) begin
      exp_v = (i < 15) ? DW'(i + 1) : 8'hAA;
      check("drain head", 64'(rdata_f), 64'(exp_v));
      rd_en = 1'b1;
      tick();
      check("drain rdata_r", 64'(rdata_r), 64'(exp_v));
      check("drain count", 64'(count_f), 64'(15 - i));
      check("drain aempty", 64'(aempty_f), 64'((15 - i) <= 2));
    end
    rd_en = 1'b0;
    check("drain empty", 64'(empty_f), 64'd1);

    // Read from empty.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf pulse", 64'(unf_f), 64'd1);
    check("unf count", 64'(count_f), 64'd0);
    check("unf rdata_r hold", 64'(rdata_r), 64'hAA);
    tick();
    check("unf clear", 64'(unf_f), 64'd0);

    // Registered-read latency.
    wr_en = 1'b1;
    wdata = 8'h11;
    tick();
    check("fwft fallthru", 64'(rdata_f), 64'h11);
    check("fwft not empty", 64'(empty_f), 64'd0);
    wdata = 8'h22;
    tick();
    wr_en = 1'b0;
    check("reg no read yet", 64'(rdata_r), 64'hAA);
    rd_en = 1'b1;
    tick();
    check("reg read 1", 64'(rdata_r), 64'h11);
    check("fwft next head", 64'(rdata_f), 64'h22);
    tick();
    rd_en = 1'b0;
    check("reg read 2", 64'(rdata_r), 64'h22);
    check("reg empty", 64'(empty_r), 64'd1);

    // Flush beats concurrent write/read.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = DW'(8'h30 + i);
      tick();
    end
    check("pre-flush count", 64'(count_f), 64'd5);
    flush = 1'b1;
    rd_en = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("flush count", 64'(count_f), 64'd0);
    check("flush empty", 64'(empty_f), 64'd1);
    check("flush ovf", 64'(ovf_f), 64'd0);
    check("flush unf", 64'(unf_f), 64'd0);
    check("flush rdata_r", 64'(rdata_r), 64'd0);

    // Asynchronous reset in the middle of a write burst.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = DW'(8'h50 + i);
      tick();
    end
    rd_en = 1'b1;
    tick();
    check("pre-reset rdata_r", 64'(rdata_r), 64'h50);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against a queue model; fill-biased first half, drain-biased second.
    mcnt = 0;
    for (int c = 0; c < 1000; c++) begin
      logic w, r, racc, wacc;
      if (c < 500) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      racc  = r && (mcnt > 0);
      wacc  = w && ((mcnt < 16) || racc);
      wr_en = w;
      rd_en = r;
      wdata = DW'($urandom);
      if (racc) begin
        exp_v = sb[0];
        check("rnd head", 64'(rdata_f), 64'(exp_v));
      end
      tick();
      if (racc) begin
        void'(sb.pop_front());
        check("rnd rdata_r", 64'(rdata_r), 64'(exp_v));
        mcnt--;
      end
      if (wacc) begin
        sb.push_back(wdata);
        mcnt++;
      end
      check("rnd count", 64'(count_f), 64'(mcnt));
      check("rnd count range", 64'(count_f <= 5'd16), 64'd1);
      check("rnd ovf", 64'(ovf_f), 64'(w && !wacc));
      check("rnd unf", 64'(unf_f), 64'(r && !racc));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
